// File: rtl/fifo_pkg.sv
// Shared constants and fill-level state encoding for the BRAM FIFO controller.
package fifo_pkg;

    localparam int ADDR_W_DEFAULT = 5;
    localparam int DEPTH          = 2 ** ADDR_W_DEFAULT;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } fill_state_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer: W-bit counter, MSB acts as the lap bit when W = ADDR_W+1.
module fifo_ptr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_d;
    logic [W-1:0] ptr_q;

    always_comb begin
        ptr_d = en ? ptr_q + W'(1) : ptr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Pointer/flag controller that turns a 32x8 dual-port RAM into a synchronous FIFO.
// Optional sticky Overflow/Underflow flags with Clr_err when BRAM_FIFO_ERR_FLAGS_EN is defined.
module bram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Wr,
    input  logic              Rd,
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    input  logic              Clr_err,
    output logic              Overflow,
    output logic              Underflow,
`endif
    output logic              WR_en,
    output logic [ADDR_W-1:0] Write_addr,
    output logic [ADDR_W-1:0] Read_addr,
    output logic              Full,
    output logic              Empty,
    output logic              Almost_full,
    output logic              Almost_empty,
    output logic [ADDR_W:0]   Count
);

    localparam int           CW      = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_W);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    fill_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          push_ok, pop_ok;
    logic [CW-1:0] wr_ptr, rd_ptr;
    logic          full, empty;

    assign full  = (state_q == S_FULL);
    assign empty = (state_q == S_EMPTY);

    // Reset_n gates the write strobe so the RAM cannot be written while reset is held.
    assign push_ok = Reset_n & Wr & (~full | Rd);
    assign pop_ok  = Rd & ~empty;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        state_d = state_q;

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            S_EMPTY: if (push_ok) state_d = S_PART;
            S_PART: begin
                if (push_ok && !pop_ok && count_q == DEPTH_C - CW'(1))
                    state_d = S_FULL;
                else if (pop_ok && !push_ok && count_q == CW'(1))
                    state_d = S_EMPTY;
            end
            S_FULL:  if (pop_ok && !push_ok) state_d = S_PART;
            default: state_d = S_EMPTY;
        endcase

        af_d = (count_d >= AF_C);
        ae_d = (count_d <= AE_C);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_EMPTY;
            count_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    fifo_ptr #(.W(CW)) u_wr_ptr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .en    (push_ok),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(CW)) u_rd_ptr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .en    (pop_ok),
        .ptr   (rd_ptr)
    );

`ifdef BRAM_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A set event in the same cycle as Clr_err wins.
    always_comb begin
        overflow_d  = (overflow_q  & ~Clr_err) | (Wr & full & ~Rd);
        underflow_d = (underflow_q & ~Clr_err) | (Rd & empty);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
`endif

    assign WR_en        = push_ok;
    assign Write_addr   = wr_ptr[ADDR_W-1:0];
    assign Read_addr    = rd_ptr[ADDR_W-1:0];
    assign Full         = full;
    assign Empty        = empty;
    assign Almost_full  = af_q;
    assign Almost_empty = ae_q;
    assign Count        = count_q;

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
Pointer/flag controller that turns the 32x8 dual-port RAM into a synchronous FIFO.
- Sequences the RAM's `WR_en`, `Write_addr` and `Read_addr` from user push/pop requests.
- Produces full/empty, almost-full/almost-empty and fill count.
- User write data goes straight to the RAM's `Write_data`.
- The RAM read port is asynchronous, so `Read_data` always shows the FIFO head.

Parameters:
- `ADDR_W`, 5, RAM address width; depth = 2**`ADDR_W` (32).
- `AF_LEVEL`, 28, `Almost_full` asserted when count >= `AF_LEVEL`.
- `AE_LEVEL`, 4, `Almost_empty` asserted when count <= `AE_LEVEL`.

Ports:
- `Clk`  in  1  rising-edge clock
- `Reset_n`  in  1  asynchronous active-low reset
- `Wr`  in  1  push request; user data presented on RAM `Write_data` same cycle
- `Rd`  in  1  pop request; head is on RAM `Read_data` this cycle
- `WR_en`  out  1  RAM write enable (combinational, = accepted push)
- `Write_addr`  out  `ADDR_W`  RAM write address (`wr_ptr` low bits)
- `Read_addr`  out  `ADDR_W`  RAM read address (`rd_ptr` low bits)
- `Full`  out  1  FIFO holds 2**`ADDR_W` entries
- `Empty`  out  1  FIFO holds 0 entries
- `Almost_full`  out  1  count >= `AF_LEVEL`
- `Almost_empty`  out  1  count <= `AE_LEVEL`
- `Count`  out  `ADDR_W`+1  current occupancy, 0..32

Behaviour:
- Reset (async, active-low): `wr_ptr` = `rd_ptr` = 0, `Count` = 0, `Empty` = 1, `Full` = 0, `Almost_empty` = 1, `Almost_full` = 0. `WR_en` = 0 while `Reset_n` low.
- Reset asserted mid-operation clears all state immediately; stored RAM contents are abandoned, not cleared.
- Pointers are `ADDR_W`+1 bits; the MSB is the wrap bit. They wrap 63 -> 0 naturally, and `Write_addr`/`Read_addr` wrap 31 -> 0.
- Accept rules, evaluated on registered flags:
  - push_ok = `Wr` & (~`Full` | `Rd`)
  - pop_ok = `Rd` & ~`Empty`
- `WR_en` = push_ok (combinational). The RAM writes at the same rising edge that `wr_ptr` increments.
- Latency:
  - A pushed word is readable the cycle after the push; `Empty` falls one cycle after the first push.
  - A pop takes effect at the edge; the next head is visible the following cycle.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- All flags are registered, derived from next-state `Count`; no combinational path from `Wr`/`Rd` to any flag.
- Fill-level states: `S_EMPTY` (count 0), `S_PART`, `S_FULL` (count 32).
  - `S_EMPTY` -> `S_PART` on push.
  - `S_PART` -> `S_FULL` on push-only at count 31.
  - `S_PART` -> `S_EMPTY` on pop-only at count 1.
  - `S_FULL` -> `S_PART` on pop-only.
- Boundary conditions:
  - Push when full without `Rd`: ignored (`WR_en` = 0, no pointer change).
  - Pop when empty: ignored, `rd_ptr` held.
  - `Wr` & `Rd` when empty: push only, the pop is ignored; count 0 -> 1.
  - `Wr` & `Rd` when full: both accepted; the reader takes the old head before the edge, the write lands at the same address at the edge; `Full` stays 1.

Optional Feature:
- Macro: `BRAM_FIFO_ERR_FLAGS_EN`.
- With the macro, add three ports:
  - `Overflow` (out, 1): sticky, set by `Wr` rejected while full.
  - `Underflow` (out, 1): sticky, set by `Rd` while empty.
  - `Clr_err` (in, 1): synchronous clear of both sticky flags; a set event in the same cycle wins over the clear.
  - Both flags reset to 0 on `Reset_n` low.
- Without the macro, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package `fifo_pkg`:
  - default `ADDR_W`
  - `DEPTH` = 2**`ADDR_W`
  - fill-state encodings `S_EMPTY`/`S_PART`/`S_FULL` (2-bit)
- Sub-module `fifo_ptr`: `ADDR_W`+1-bit wrap counter with enable and async active-low reset. Instantiated twice, once for write and once for read.

Test Plan:
- Reset -> `Empty`=1, `Full`=0, `Count`=0, `Almost_empty`=1, both addresses = 0; then `Reset_n`=0 mid-fill at count 10 -> all flags/count back to reset values within the same cycle.
- Push 0x01..0x20 (32 words) -> `Full`=1 after 32nd edge, `Almost_full` from count 28. A 33rd `Wr` alone -> `WR_en`=0, `Count` stays 32, `Overflow`=1 with macro.
- Drain 32 pops -> `Read_data` sequence 0x01..0x20, `Empty`=1 at end. Extra `Rd` -> `Read_addr` unchanged, `Underflow`=1 with macro; `Clr_err` -> both flags 0.
- Empty FIFO, `Wr`=`Rd`=1 with data 0xAA -> push only, `Count`=1, `Read_data`=0xAA next cycle.
- Full FIFO, `Wr`=`Rd`=1 with data 0x55 -> old head popped, `Count`=32, `Full`=1, 0x55 emerges last after 31 further pops.
- 100 push/pop pairs from count 3 -> addresses wrap 31->0 repeatedly, data order preserved, `Count` stays 3, `Almost_empty`=1 throughout.
